riscv_mc_cpu: RTL and testbench



---
 rtl/riscv_mc_cpu_pkg.sv | 61 ++++++
 rtl/riscv_mc_regfile.sv | 39 +++
 rtl/riscv_mc_cpu.sv | 315 +++++++++++++++++++++++++++++++
 tb/tb_riscv_mc_cpu.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mc_cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I/RV32E core: opcode and
// funct codes, FSM state encoding, trap cause codes and ALU operations.
package riscv_mc_cpu_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Load/store width funct3
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] INSN_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSN_EBREAK = 32'h0010_0073;

    localparam logic [1:0] TRAP_ECALL    = 2'd0;
    localparam logic [1:0] TRAP_ILLEGAL  = 2'd1;
    localparam logic [1:0] TRAP_MISALIGN = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;

endpackage

// File: rtl/riscv_mc_regfile.sv
// Architectural register file.
//   clk, reset_n : clock, async active-low reset (clears every entry)
//   ra1/rd1      : async read port 1
//   ra2/rd2      : async read port 2
//   we/wa/wd     : synchronous write port
// x0 and indices >= NUM_REGS always read 0 and are never written.
module riscv_mc_regfile #(
    parameter int NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  ra1,
    output logic [31:0] rd1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    localparam int AW = $clog2(NUM_REGS);

    logic [31:0] regs [NUM_REGS];

    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (ra1 != 5'd0 && int'(ra1) < NUM_REGS) rd1 = regs[ra1[AW-1:0]];
        if (ra2 != 5'd0 && int'(ra2) < NUM_REGS) rd2 = regs[ra2[AW-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we && wa != 5'd0 && int'(wa) < NUM_REGS) begin
            regs[wa[AW-1:0]] <= wd;
        end
    end

endmodule

// File: rtl/riscv_mc_cpu.sv
// Multi-cycle RV32I/RV32E core on a single valid/ready memory bus.
//   clk, reset_n          : clock, async active-low reset
//   PC                    : address of the instruction executing
//   mem_valid/mem_ready   : bus handshake
//   mem_instr             : request is an instruction fetch
//   mem_addr              : word-aligned address
//   mem_wdata/mem_wstrb   : store data (lanes replicated) / byte strobes
//   mem_rdata             : read data
//   halted/trap_cause     : core stopped and why (0 ecall/ebreak,
//                           1 illegal, 2 misaligned)
//
// state  | meaning
// IDLE   | one cycle after reset release
// FETCH  | bus read of instruction at PC, latch IR
// DECODE | legality / register-range check, ecall/ebreak trap
// EXEC   | ALU, branch resolve, jump target, effective address
// MEM    | load/store bus cycle
// WB     | write rd, PC <= next_pc
// HALT   | terminal until reset
module riscv_mc_cpu
    import riscv_mc_cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          NUM_REGS = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] PC,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_instr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata,
    output logic        halted,
    output logic [1:0]  trap_cause
);
    state_t      state, state_nx;
    logic [31:0] ir, pc_r, ea, result, next_pc;
    logic [1:0]  cause;

    logic [6:0]  opcode, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] rs1_val, rs2_val, imm;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign f3     = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign f7     = ir[31:25];

    logic is_load, is_store, is_jump;
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_jump  = (opcode == OP_JAL) || (opcode == OP_JALR);

    logic use_rd, use_rs1, use_rs2, legal, is_sys, decode_fault;
    logic rf_we;

    // Registers are read straight from IR in EXEC/MEM; nothing writes the
    // file between DECODE and WB, so this matches a DECODE-time read.
    riscv_mc_regfile #(.NUM_REGS(NUM_REGS)) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .ra1     (rs1),
        .rd1     (rs1_val),
        .ra2     (rs2),
        .rd2     (rs2_val),
        .we      (rf_we),
        .wa      (rd),
        .wd      (result)
    );

    always_comb begin
        unique case (opcode)
            OP_STORE:          imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OP_BRANCH:         imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OP_LUI, OP_AUIPC:  imm = {ir[31:12], 12'b0};
            OP_JAL:            imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:           imm = {{20{ir[31]}}, ir[31:20]};
        endcase
    end

    always_comb begin
        legal   = 1'b0;
        is_sys  = 1'b0;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OP_LUI, OP_AUIPC, OP_JAL: begin
                legal  = 1'b1;
                use_rd = 1'b1;
            end
            OP_JALR: begin
                legal   = (f3 == 3'b000);
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_BRANCH: begin
                legal   = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_LOAD: begin
                legal   = f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_STORE: begin
                legal   = f3 inside {F3_B, F3_H, F3_W};
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_IMM: begin
                if (f3 == F3_SLL)     legal = (f7 == F7_BASE);
                else if (f3 == F3_SR) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
                else                  legal = 1'b1;
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
            end
            OP_REG: begin
                legal   = (f7 == F7_BASE) || (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR));
                use_rd  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OP_FENCE:  legal = (f3 == 3'b000);
            OP_SYSTEM: begin
                legal  = (ir == INSN_ECALL) || (ir == INSN_EBREAK);
                is_sys = legal;
            end
            default: ;
        endcase
        decode_fault = !legal
                    || (use_rd  && int'(rd)  >= NUM_REGS)
                    || (use_rs1 && int'(rs1) >= NUM_REGS)
                    || (use_rs2 && int'(rs2) >= NUM_REGS);
    end

    alu_op_t     alu_op;
    logic [31:0] alu_b, alu_res;

    always_comb begin
        alu_b  = (opcode == OP_REG) ? rs2_val : imm;
        alu_op = ALU_ADD;
        case (f3)
            F3_ADD:  alu_op = (opcode == OP_REG && f7[5]) ? ALU_SUB : ALU_ADD;
            F3_SLL:  alu_op = ALU_SLL;
            F3_SLT:  alu_op = ALU_SLT;
            F3_SLTU: alu_op = ALU_SLTU;
            F3_XOR:  alu_op = ALU_XOR;
            F3_SR:   alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            F3_OR:   alu_op = ALU_OR;
            F3_AND:  alu_op = ALU_AND;
            default: alu_op = ALU_ADD;
        endcase
        case (alu_op)
            ALU_SUB:  alu_res = rs1_val - alu_b;
            ALU_SLL:  alu_res = rs1_val << alu_b[4:0];
            ALU_SLT:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            ALU_SLTU: alu_res = {31'b0, rs1_val < alu_b};
            ALU_XOR:  alu_res = rs1_val ^ alu_b;
            ALU_SRL:  alu_res = rs1_val >> alu_b[4:0];
            ALU_SRA:  alu_res = $signed(rs1_val) >>> alu_b[4:0];
            ALU_OR:   alu_res = rs1_val | alu_b;
            ALU_AND:  alu_res = rs1_val & alu_b;
            default:  alu_res = rs1_val + alu_b;
        endcase
    end

    logic [31:0] pc_plus4, pc_rel, jump_target, ea_c, exec_value;
    logic        taken, misalign_c, exec_fault;

    always_comb begin
        pc_plus4    = pc_r + 32'd4;
        pc_rel      = pc_r + imm;
        jump_target = (opcode == OP_JALR) ? ((rs1_val + imm) & ~32'h1) : pc_rel;
        ea_c        = rs1_val + imm;
        misalign_c  = (f3[1:0] == 2'b01 && ea_c[0]) || (f3[1:0] == 2'b10 && ea_c[1:0] != 2'b00);
        case (f3)
            F3_BEQ:  taken = (rs1_val == rs2_val);
            F3_BNE:  taken = (rs1_val != rs2_val);
            F3_BLT:  taken = ($signed(rs1_val) < $signed(rs2_val));
            F3_BGE:  taken = ($signed(rs1_val) >= $signed(rs2_val));
            F3_BLTU: taken = (rs1_val < rs2_val);
            F3_BGEU: taken = (rs1_val >= rs2_val);
            default: taken = 1'b0;
        endcase
        exec_fault = (is_jump && jump_target[1]) || ((is_load || is_store) && misalign_c);
        case (opcode)
            OP_LUI:           exec_value = imm;
            OP_AUIPC:         exec_value = pc_rel;
            OP_JAL, OP_JALR:  exec_value = pc_plus4;
            default:          exec_value = alu_res;
        endcase
    end

    logic [31:0] byte_lane, half_lane, load_value, wdata_c;
    logic [3:0]  wstrb_c;

    always_comb begin
        byte_lane = mem_rdata >> {ea[1:0], 3'b000};
        half_lane = mem_rdata >> {ea[1], 4'b0000};
        case (f3)
            F3_B:    load_value = {{24{byte_lane[7]}}, byte_lane[7:0]};
            F3_H:    load_value = {{16{half_lane[15]}}, half_lane[15:0]};
            F3_BU:   load_value = {24'b0, byte_lane[7:0]};
            F3_HU:   load_value = {16'b0, half_lane[15:0]};
            default: load_value = mem_rdata;
        endcase
        case (f3[1:0])
            2'b00: begin
                wdata_c = {4{rs2_val[7:0]}};
                wstrb_c = 4'b0001 << ea[1:0];
            end
            2'b01: begin
                wdata_c = {2{rs2_val[15:0]}};
                wstrb_c = 4'b0011 << ea[1:0];
            end
            default: begin
                wdata_c = rs2_val;
                wstrb_c = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:   state_nx = S_FETCH;
            S_FETCH:  if (mem_ready) state_nx = S_DECODE;
            S_DECODE: state_nx = (decode_fault || is_sys) ? S_HALT : S_EXEC;
            S_EXEC: begin
                if (exec_fault)                  state_nx = S_HALT;
                else if (opcode == OP_BRANCH)    state_nx = S_FETCH;
                else if (is_load || is_store)    state_nx = S_MEM;
                else                             state_nx = S_WB;
            end
            S_MEM:    if (mem_ready) state_nx = is_store ? S_FETCH : S_WB;
            S_WB:     state_nx = S_FETCH;
            S_HALT:   state_nx = S_HALT;
            default:  state_nx = S_IDLE;
        endcase
    end

    // Bus outputs decode from the state register only, so they hold steady
    // through wait states and drop as soon as reset_n falls.
    always_comb begin
        mem_valid = 1'b0;
        mem_instr = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = '0;
        if (state == S_FETCH) begin
            mem_valid = 1'b1;
            mem_instr = 1'b1;
            mem_addr  = pc_r;
        end else if (state == S_MEM) begin
            mem_valid = 1'b1;
            mem_addr  = {ea[31:2], 2'b00};
            if (is_store) begin
                mem_wdata = wdata_c;
                mem_wstrb = wstrb_c;
            end
        end
    end

    assign rf_we      = (state == S_WB) && use_rd && (rd != 5'd0);
    assign PC         = pc_r;
    assign halted     = (state == S_HALT);
    assign trap_cause = cause;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc_r    <= RESET_PC;
            ir      <= '0;
            ea      <= '0;
            result  <= '0;
            next_pc <= RESET_PC;
            cause   <= TRAP_ECALL;
        end else begin
            state <= state_nx;
            case (state)
                S_FETCH: if (mem_ready) ir <= mem_rdata;
                S_DECODE: begin
                    if (decode_fault) cause <= TRAP_ILLEGAL;
                    else if (is_sys)  cause <= TRAP_ECALL;
                end
                S_EXEC: begin
                    ea      <= ea_c;
                    result  <= exec_value;
                    next_pc <= is_jump ? jump_target : pc_plus4;
                    if (exec_fault)
                        cause <= TRAP_MISALIGN;
                    else if (opcode == OP_BRANCH)
                        pc_r <= taken ? pc_rel : pc_plus4;
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (is_store) pc_r   <= pc_plus4;
                        else          result <= load_value;
                    end
                end
                S_WB:    pc_r <= next_pc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mc_cpu.sv
`timescale 1ns/1ps
module tb_riscv_mc_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main core, RV32I
    logic        reset_n;
    logic [31:0] pc;
    logic        mem_valid, mem_ready, mem_instr;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        halted;
    logic [1:0]  trap_cause;

    // second core, RV32E, zero-wait memory
    logic        reset16;
    logic [31:0] pc16;
    logic        valid16, instr16;
    logic        ready16;
    logic [31:0] addr16, wdata16, rdata16;
    logic [3:0]  wstrb16;
    logic        halted16;
    logic [1:0]  trap16;

    logic [31:0] mem   [64];
    logic [31:0] mem16 [16];

    int wait_cfg, cnt, cyc, wr_count;
    logic [31:0] fq_addr [$];
    int          fq_cyc  [$];
    int total, bad;

    riscv_mc_cpu #(.RESET_PC(32'h0), .NUM_REGS(32)) dut (
        .clk(clk), .reset_n(reset_n), .PC(pc),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_instr(mem_instr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .halted(halted), .trap_cause(trap_cause)
    );

    riscv_mc_cpu #(.RESET_PC(32'h0), .NUM_REGS(16)) dut16 (
        .clk(clk), .reset_n(reset16), .PC(pc16),
        .mem_valid(valid16), .mem_ready(ready16), .mem_instr(instr16),
        .mem_addr(addr16), .mem_wdata(wdata16), .mem_wstrb(wstrb16),
        .mem_rdata(rdata16), .halted(halted16), .trap_cause(trap16)
    );

    assign mem_rdata = mem[mem_addr[7:2]];
    assign rdata16   = mem16[addr16[5:2]];

    always @(posedge clk) cyc = cyc + 1;

    // Memory responder: ready after wait_cfg stall cycles per request.
    always @(negedge clk) begin
        if (mem_ready || !mem_valid) cnt = 0;
        mem_ready = 1'b0;
        if (mem_valid) begin
            if (cnt >= wait_cfg) begin
                mem_ready = 1'b1;
                if (mem_instr) begin
                    fq_addr.push_back(mem_addr);
                    fq_cyc.push_back(cyc);
                end else if (mem_wstrb != 4'b0000) begin
                    for (int b = 0; b < 4; b++)
                        if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] = mem_wdata[8*b +: 8];
                    wr_count = wr_count + 1;
                end
            end else begin
                cnt = cnt + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fa(input int i);
        return (i < fq_addr.size()) ? fq_addr[i] : 32'hFFFF_FFFF;
    endfunction

    function automatic int fc(input int i);
        return (i < fq_cyc.size()) ? fq_cyc[i] : -1000;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0013;
    endtask

    task automatic start(input int w);
        reset_n  = 1'b0;
        wait_cfg = w;
        repeat (2) @(negedge clk);
        #1;
        fq_addr.delete();
        fq_cyc.delete();
        wr_count = 0;
    endtask

    task automatic release_rst();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wait_halt(input string tag, input int max);
        int n;
        n = 0;
        while (!halted && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(halted), 32'd1);
    endtask

    task automatic wait_fetches(input string tag, input int k, input int max);
        int n;
        n = 0;
        while (fq_addr.size() < k && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(fq_addr.size() >= k), 32'd1);
    endtask

    task automatic wait_store_req(input string tag, input int max);
        int n;
        n = 0;
        while (!(mem_valid && !mem_instr) && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(mem_valid && !mem_instr), 32'd1);
    endtask

    task automatic wait_halt16(input string tag, input int max);
        int n;
        n = 0;
        while (!halted16 && n < max) begin
            @(negedge clk); #1;
            n++;
        end
        chk(tag, 32'(halted16), 32'd1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        total = 0; bad = 0; cnt = 0; cyc = 0; wr_count = 0;
        wait_cfg = 0; mem_ready = 1'b0; reset_n = 1'b0;
        reset16 = 1'b0; ready16 = 1'b1;
        for (int i = 0; i < 16; i++) mem16[i] = 32'h0000_0013;

        // ADDI/ADDI/LW/SW/ECALL with zero-wait memory
        clear_mem();
        mem[0] = 32'h0050_0093;  // addi x1,x0,5
        mem[1] = 32'hFF90_8113;  // addi x2,x1,-7
        mem[2] = 32'h0040_2203;  // lw   x4,4(x0)
        mem[3] = 32'h0410_2023;  // sw   x1,0x40(x0)
        mem[4] = 32'h0000_0073;  // ecall
        start(0);
        chk("rst_pc",     pc,                  32'h0);
        chk("rst_valid",  32'(mem_valid),      32'd0);
        chk("rst_wstrb",  32'(mem_wstrb),      32'd0);
        chk("rst_halted", 32'(halted),         32'd0);
        chk("rst_cause",  32'(trap_cause),     32'd0);
        release_rst();
        wait_halt("s1_halt", 200);
        chk("s1_fetch0", fa(0), 32'h00);
        chk("s1_fetch1", fa(1), 32'h04);
        chk("s1_fetch4", fa(4), 32'h10);
        chk("s1_lat_addi1", 32'(fc(1) - fc(0)), 32'd4);
        chk("s1_lat_addi2", 32'(fc(2) - fc(1)), 32'd4);
        chk("s1_lat_load",  32'(fc(3) - fc(2)), 32'd5);
        chk("s1_lat_store", 32'(fc(4) - fc(3)), 32'd4);
        chk("s1_x1", dut.u_regfile.regs[1], 32'h0000_0005);
        chk("s1_x2", dut.u_regfile.regs[2], 32'hFFFF_FFFE);
        chk("s1_x4", dut.u_regfile.regs[4], 32'hFF90_8113);
        chk("s1_mem40", mem[16], 32'h0000_0005);
        chk("s1_cause", 32'(trap_cause), 32'd0);
        chk("s1_pc", pc, 32'h10);

        // 3 wait states per request: SW then LB
        clear_mem();
        mem[0] = 32'hFFE0_0113;  // addi x2,x0,-2
        mem[1] = 32'h0020_2023;  // sw   x2,0(x0)
        mem[2] = 32'h0010_0183;  // lb   x3,1(x0)
        mem[3] = 32'h0000_0073;  // ecall
        start(3);
        chk("rst_x1_cleared", dut.u_regfile.regs[1], 32'h0);
        release_rst();
        wait_store_req("s2_store_seen", 300);
        chk("s2_stalled", 32'(mem_ready), 32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("s2_addr",  mem_addr,        32'h0);
            chk("s2_wdata", mem_wdata,       32'hFFFF_FFFE);
            chk("s2_wstrb", 32'(mem_wstrb),  32'hF);
            chk("s2_valid", 32'(mem_valid),  32'd1);
            @(negedge clk); #1;
        end
        wait_halt("s2_halt", 300);
        chk("s2_mem0", mem[0], 32'hFFFF_FFFE);
        chk("s2_x3", dut.u_regfile.regs[3], 32'hFFFF_FFFF);
        chk("s2_writes", 32'(wr_count), 32'd1);
        chk("s2_pc", pc, 32'h0C);

        // taken branch back to 0x08
        clear_mem();
        mem[4] = 32'hFE00_0CE3;  // beq x0,x0,-8
        start(0);
        release_rst();
        wait_fetches("s3a_fetches", 6, 200);
        chk("s3a_br_fetch", fa(4), 32'h10);
        chk("s3a_target",   fa(5), 32'h08);
        chk("s3a_lat",      32'(fc(5) - fc(4)), 32'd3);

        // not-taken branch falls through
        clear_mem();
        mem[4] = 32'hFE00_1CE3;  // bne x0,x0,-8
        mem[5] = 32'h0000_0073;
        start(0);
        release_rst();
        wait_halt("s3b_halt", 200);
        chk("s3b_next", fa(5), 32'h14);
        chk("s3b_lat",  32'(fc(5) - fc(4)), 32'd3);

        // misaligned JALR target
        clear_mem();
        mem[0] = 32'h0550_0093;  // addi x1,x0,0x55
        mem[8] = 32'h0060_00E7;  // jalr x1,x0,6
        start(0);
        release_rst();
        wait_halt("s4_halt", 300);
        chk("s4_cause", 32'(trap_cause), 32'd2);
        chk("s4_pc",    pc, 32'h20);
        chk("s4_x1",    dut.u_regfile.regs[1], 32'h55);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            chk("s4_valid_low", 32'(mem_valid), 32'd0);
        end

        // RV32E: out-of-range register, then ecall
        mem16[0] = 32'h0010_0A13;  // addi x20,x0,1
        @(negedge clk); reset16 = 1'b1;
        wait_halt16("s5_halt_ill", 50);
        chk("s5_cause_ill", 32'(trap16), 32'd1);
        chk("s5_pc_ill",    pc16, 32'h0);
        reset16 = 1'b0;
        mem16[0] = 32'h0000_0073;
        repeat (2) @(negedge clk);
        #1;
        chk("s5_rst_cause", 32'(trap16), 32'd0);
        reset16 = 1'b1;
        wait_halt16("s5_halt_ecall", 50);
        chk("s5_cause_ecall", 32'(trap16), 32'd0);

        // reset during a stalled store
        clear_mem();
        mem[0]  = 32'h0400_2023;  // sw x0,0x40(x0)
        mem[16] = 32'hDEAD_BEEF;
        start(3);
        release_rst();
        wait_store_req("s6_store_seen", 300);
        @(negedge clk); #2;
        reset_n = 1'b0;
        #1;
        chk("s6_valid_drop", 32'(mem_valid), 32'd0);
        chk("s6_wstrb_drop", 32'(mem_wstrb), 32'd0);
        repeat (2) @(negedge clk);
        #1;
        chk("s6_mem_kept", mem[16], 32'hDEAD_BEEF);
        chk("s6_no_write", 32'(wr_count), 32'd0);
        fq_addr.delete();
        fq_cyc.delete();
        release_rst();
        wait_fetches("s6_refetch", 1, 100);
        chk("s6_fetch_addr", fa(0), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
